// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle base ops plus bit-serial multiply and restoring divide,
// one operation in flight behind valid/ready handshakes on both sides.
module alu_multicycle #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      opcode,
  input  logic [XLEN-1:0] left,
  input  logic [XLEN-1:0] right,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int SH_W = $clog2(XLEN);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;
  localparam logic [3:0] OP_DIVU  = 4'd12;
  localparam logic [3:0] OP_REMU  = 4'd13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              armed_q;
  logic [3:0]        op_q;
  logic [XLEN-1:0]   a_q, b_q, hi_q, lo_q, res_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              accept, last_iter;
  logic [2*XLEN-1:0] step;
  logic [XLEN-1:0]   iter_res;

  function automatic logic is_iter(input logic [3:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

  function automatic logic is_mul(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULHU);
  endfunction

  function automatic logic [XLEN-1:0] base_op(input logic [3:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa, sb;
    logic [SH_W-1:0]        sh;
    sa = a;
    sb = b;
    sh = b[SH_W-1:0];
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << sh;
      OP_SRL:  return a >> sh;
      OP_SRA:  return sa >>> sh;
      OP_SLT:  return {{(XLEN-1){1'b0}}, (sa < sb)};
      OP_SLTU: return {{(XLEN-1){1'b0}}, (a < b)};
      default: return '0;
    endcase
  endfunction

  // One shift-add step: {hi,lo} holds partial product high half and remaining multiplier bits.
  function automatic logic [2*XLEN-1:0] mul_step(input logic [XLEN-1:0] hi,
                                                 input logic [XLEN-1:0] lo,
                                                 input logic [XLEN-1:0] mcand);
    logic [XLEN:0] sum;
    sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(XLEN+1){1'b0}});
    return {sum, lo[XLEN-1:1]};
  endfunction

  // One restoring step: rem < dvsr holds on entry, so the shifted value fits XLEN+1 bits.
  function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] rem,
                                                 input logic [XLEN-1:0] quo,
                                                 input logic [XLEN-1:0] dvsr);
    logic [XLEN:0] shifted, diff;
    shifted = {rem, quo[XLEN-1]};
    diff    = shifted - {1'b0, dvsr};
    if (!diff[XLEN]) return {diff[XLEN-1:0], quo[XLEN-2:0], 1'b1};
    else             return {shifted[XLEN-1:0], quo[XLEN-2:0], 1'b0};
  endfunction

  assign accept    = in_valid & in_ready;
  assign last_iter = (state_q == BUSY) && (cnt_q == CNT_W'(XLEN-1));

  always_comb begin
    step     = is_mul(op_q) ? mul_step(hi_q, lo_q, a_q) : div_step(hi_q, lo_q, b_q);
    iter_res = '0;
    case (op_q)
      OP_MUL:   iter_res = step[XLEN-1:0];
      OP_MULHU: iter_res = step[2*XLEN-1:XLEN];
      OP_DIVU:  iter_res = (b_q == '0) ? '1 : step[XLEN-1:0];
      default:  iter_res = (b_q == '0) ? a_q : step[2*XLEN-1:XLEN];
    endcase
  end

  // State register; in_ready stays low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = is_iter(opcode) ? BUSY : DONE;
      BUSY:    if (last_iter) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) && armed_q;
    out_valid = (state_q == DONE);
    busy      = (state_q == BUSY);
  end

  // Operand latch on accept, then one iteration per BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      cnt_q <= '0;
      res_q <= '0;
    end else if (accept) begin
      op_q  <= opcode;
      a_q   <= left;
      b_q   <= right;
      hi_q  <= '0;
      lo_q  <= is_mul(opcode) ? right : left;
      cnt_q <= '0;
      if (!is_iter(opcode)) res_q <= base_op(opcode, left, right);
    end else if (state_q == BUSY) begin
      {hi_q, lo_q} <= step;
      cnt_q        <= cnt_q + CNT_W'(1);
      if (last_iter) res_q <= iter_res;
    end
  end

  assign result = res_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: directed and random operations on XLEN=32 and XLEN=8 instances,
// checked against an arithmetic reference model.
module tb_alu_multicycle;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0]  opcode;
  logic [31:0] left, right, result;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [3:0]  opcode8;
  logic [7:0]  left8, right8, result8;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp32;
  logic        iter32;

  alu_multicycle #(.XLEN(32), .CNT_W(6)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .left(left), .right(right), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  alu_multicycle #(.XLEN(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .opcode(opcode8), .left(left8), .right(right8), .out_valid(out_valid8),
    .out_ready(out_ready8), .result(result8), .busy(busy8)
  );

  function automatic logic [63:0] ref_model(input logic [3:0] op, input logic [63:0] a_in,
                                            input logic [63:0] b_in, input int w);
    logic [63:0]   mask, a, b, p;
    longint signed sa, sb, t;
    int            sh;
    mask = (64'd1 << w) - 64'd1;
    a    = a_in & mask;
    b    = b_in & mask;
    sh   = int'(b % 64'(w));
    sa   = a[w-1] ? signed'(a | ~mask) : signed'(a);
    sb   = b[w-1] ? signed'(b | ~mask) : signed'(b);
    p    = a * b;
    case (op)
      4'd0:  return (a + b) & mask;
      4'd1:  return (a - b) & mask;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return (a << sh) & mask;
      4'd6:  return a >> sh;
      4'd7:  begin t = sa >>> sh; return t & mask; end
      4'd8:  return (sa < sb) ? 64'd1 : 64'd0;
      4'd9:  return (a < b) ? 64'd1 : 64'd0;
      4'd10: return p & mask;
      4'd11: return (p >> w) & mask;
      4'd12: return (b == 0) ? mask : a / b;
      4'd13: return (b == 0) ? a : a % b;
      default: return 64'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int t;
    exp32  = 32'(ref_model(op, 64'(a), 64'(b), 32));
    iter32 = (op >= 4'd10) && (op <= 4'd13);
    @(negedge clk);
    in_valid = 1'b1; opcode = op; left = a; right = b;
    t = 0;
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check("accept wait", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic collect32(input string tag, input int hold);
    int cyc, nb;
    cyc = 1;
    nb  = busy ? 1 : 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (busy) nb++;
    end
    check({tag, " latency"}, 64'(cyc), iter32 ? 64'd33 : 64'd1);
    check({tag, " busy"}, 64'(nb), iter32 ? 64'd32 : 64'd0);
    check(tag, 64'(result), 64'(exp32));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold"}, 64'({result, in_ready, out_valid}), 64'({exp32, 1'b0, 1'b1}));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " taken"}, 64'(out_valid), 64'd0);
  endtask

  task automatic run32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string tag, input int hold);
    send32(op, a, b);
    in_valid = 1'b0;
    opcode   = 4'($urandom);
    left     = $urandom;
    right    = $urandom;
    collect32(tag, hold);
  endtask

  task automatic run8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input string tag);
    int t, cyc;
    logic [7:0] e;
    e = 8'(ref_model(op, 64'(a), 64'(b), 8));
    @(negedge clk);
    in_valid8 = 1'b1; opcode8 = op; left8 = a; right8 = b;
    t = 0;
    while (!in_ready8 && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check({tag, " accept wait"}, 64'(in_ready8), 64'd1);
    @(posedge clk); #1;
    in_valid8 = 1'b0; left8 = 8'($urandom); right8 = 8'($urandom);
    cyc = 1;
    while (!out_valid8 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    check({tag, " latency"}, 64'(cyc), (op >= 4'd10 && op <= 4'd13) ? 64'd9 : 64'd1);
    check(tag, 64'(result8), 64'(e));
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    logic [31:0] rb;
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; opcode = '0; left = '0; right = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; opcode8 = '0; left8 = '0; right8 = '0;

    @(posedge clk); #1;
    check("reset outputs", 64'({out_valid, busy, in_ready}), 64'd0);
    check("reset result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready before clk", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    check("in_ready after clk", 64'(in_ready), 64'd1);

    run32(4'd0, 32'd4, 32'd3, "ADD", 0);
    run32(4'd1, 32'd7, 32'd3, "SUB", 0);
    run32(4'd2, 32'hC, 32'hA, "AND", 0);
    run32(4'd1, 32'd0, 32'd1, "SUB wrap", 0);
    run32(4'd7, 32'h8000_0000, 32'd4, "SRA", 0);
    run32(4'd8, 32'hFFFF_FFFF, 32'd1, "SLT", 0);
    run32(4'd9, 32'hFFFF_FFFF, 32'd1, "SLTU", 0);
    run32(4'd14, 32'h1234, 32'h5678, "reserved", 0);

    run32(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MUL", 0);
    run32(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHU", 0);

    run32(4'd12, 32'd100, 32'd7, "DIVU", 0);
    run32(4'd13, 32'd100, 32'd7, "REMU", 0);
    run32(4'd12, 32'd5, 32'd0, "DIVU by 0", 0);
    run32(4'd13, 32'd5, 32'd0, "REMU by 0", 0);

    run32(4'd12, 32'd1000, 32'd7, "DIVU held", 5);

    // in_valid stays high through the op; next op must wait until after the handshake edge
    send32(4'd12, 32'd1000, 32'd7);
    opcode = 4'd0; left = 32'd1; right = 32'd2;
    collect32("DIVU in_valid held", 0);
    check("no accept on handshake edge", 64'({in_ready, out_valid}), 64'd2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("next op result", 64'({out_valid, result}), 64'({1'b1, 32'd3}));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Asynchronous reset in the middle of a divide
    send32(4'd12, 32'hDEAD, 32'd3);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid-op reset outputs", 64'({out_valid, busy, in_ready}), 64'd0);
    check("mid-op reset result", 64'(result), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready after mid-op reset", 64'(in_ready), 64'd1);
    nv = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid || busy) nv++;
    end
    check("aborted op silent", 64'(nv), 64'd0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 255));
        default: rb = $urandom;
      endcase
      run32(4'($urandom_range(0, 15)), $urandom, rb, "random32", int'($urandom_range(0, 2)));
    end

    run8(4'd10, 8'h10, 8'h10, "MUL8");
    run8(4'd11, 8'h10, 8'h10, "MULHU8");
    run8(4'd12, 8'hFF, 8'h10, "DIVU8");
    for (int i = 0; i < 20; i++) begin
      run8(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom_range(0, 255)), "random8");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
